// File: rtl/mask_bbox.sv
// Foreground bounding box and pixel count over a binary mask frame held in BRAM.
// Optional box-outline draw pass is compiled in with `define MASK_BBOX_DRAW_EN.
module mask_bbox #(
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          MIN_PIXELS = 64,
  parameter logic [7:0]  BOX_VALUE  = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  output logic        done,
  output logic        busy,
  input  logic [7:0]  mask_in,
  output logic [16:0] addr_read,
  output logic        we,
  output logic [16:0] addr_write,
  output logic [7:0]  data_out,
  output logic [8:0]  x_min,
  output logic [8:0]  x_max,
  output logic [7:0]  y_min,
  output logic [7:0]  y_max,
  output logic [16:0] pix_count,
  output logic        box_valid
);

  localparam logic [16:0] LAST_ADDR = 17'(IMG_W * IMG_H - 1);
  localparam logic [8:0]  X_LAST    = 9'(IMG_W - 1);
  localparam logic [7:0]  Y_LAST    = 8'(IMG_H - 1);
  localparam logic [16:0] MIN_CNT   = 17'(MIN_PIXELS);

  typedef enum logic [2:0] {IDLE, SCAN, FLUSH, FINISH, DRAW, DONE} state_t;
  state_t state, nxt;

  logic        vld_p0;
  logic [8:0]  px_p0;
  logic [7:0]  py_p0;
  logic [8:0]  xmin_p1, xmax_p1;
  logic [7:0]  ymin_p1, ymax_p1;
  logic [16:0] cnt_p1;
  logic        pub_valid;
  logic        draw_go;
  logic        draw_last;

  assign pub_valid = (cnt_p1 != '0) && (cnt_p1 >= MIN_CNT);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (active && !done) nxt = SCAN;
      SCAN:    if (addr_read >= LAST_ADDR) nxt = FLUSH;
      FLUSH:   nxt = FINISH;
      FINISH:  nxt = draw_go ? DRAW : DONE;
      DRAW:    if (draw_last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      busy      <= 1'b0;
      addr_read <= '0;
      vld_p0    <= 1'b0;
      px_p0     <= '0;
      py_p0     <= '0;
      xmin_p1   <= '0;
      xmax_p1   <= '0;
      ymin_p1   <= '0;
      ymax_p1   <= '0;
      cnt_p1    <= '0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      pix_count <= '0;
      box_valid <= 1'b0;
    end else begin
      state  <= nxt;
      busy   <= (nxt == SCAN) || (nxt == FLUSH) || (nxt == FINISH) || (nxt == DRAW);
      vld_p0 <= (state == SCAN);
      if (state == SCAN && !(addr_read >= LAST_ADDR)) addr_read <= addr_read + 17'd1;
      else                                            addr_read <= '0;

      if (state == IDLE) begin
        if (active && !done) begin
          xmin_p1 <= X_LAST;
          ymin_p1 <= Y_LAST;
          xmax_p1 <= '0;
          ymax_p1 <= '0;
          cnt_p1  <= '0;
          px_p0   <= '0;
          py_p0   <= '0;
        end
        if (done && !active) done <= 1'b0;
      end

      // p0 -> p1: pixel data arrives one cycle behind its address
      if (vld_p0) begin
        if (|mask_in) begin
          cnt_p1 <= cnt_p1 + 17'd1;
          if (px_p0 < xmin_p1) xmin_p1 <= px_p0;
          if (px_p0 > xmax_p1) xmax_p1 <= px_p0;
          if (py_p0 < ymin_p1) ymin_p1 <= py_p0;
          if (py_p0 > ymax_p1) ymax_p1 <= py_p0;
        end
        if (px_p0 == X_LAST) begin
          px_p0 <= '0;
          py_p0 <= py_p0 + 8'd1;
        end else begin
          px_p0 <= px_p0 + 9'd1;
        end
      end

      // p1 -> published results; an empty frame reports a zero box
      if (state == FINISH) begin
        pix_count <= cnt_p1;
        box_valid <= pub_valid;
        x_min     <= (cnt_p1 == '0) ? '0 : xmin_p1;
        x_max     <= (cnt_p1 == '0) ? '0 : xmax_p1;
        y_min     <= (cnt_p1 == '0) ? '0 : ymin_p1;
        y_max     <= (cnt_p1 == '0) ? '0 : ymax_p1;
      end

      if (state == DONE) done <= 1'b1;
    end
  end

`ifdef MASK_BBOX_DRAW_EN
  logic [8:0] dx;
  logic [7:0] dy;
  logic       on_h, on_v;

  assign draw_go   = pub_valid;
  assign draw_last = (addr_write >= LAST_ADDR);
  assign on_h      = ((dy == y_min) || (dy == y_max)) && (dx >= x_min) && (dx <= x_max);
  assign on_v      = ((dx == x_min) || (dx == x_max)) && (dy >= y_min) && (dy <= y_max);
  assign we        = (state == DRAW) && (on_h || on_v);
  assign data_out  = we ? BOX_VALUE : 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_write <= '0;
      dx         <= '0;
      dy         <= '0;
    end else if (state == FINISH) begin
      addr_write <= '0;
      dx         <= '0;
      dy         <= '0;
    end else if (state == DRAW && !draw_last) begin
      addr_write <= addr_write + 17'd1;
      if (dx == X_LAST) begin
        dx <= '0;
        dy <= dy + 8'd1;
      end else begin
        dx <= dx + 9'd1;
      end
    end
  end
`else
  assign draw_go    = 1'b0;
  assign draw_last  = 1'b1;
  assign we         = 1'b0;
  assign addr_write = '0;
  assign data_out   = '0;
`endif

endmodule

// File: tb/tb_mask_bbox.sv
// Bench for mask_bbox on a reduced 64x48 frame: table vectors, random frames, reset abort.
module tb_mask_bbox;
  localparam int W    = 64;
  localparam int H    = 48;
  localparam int N    = W * H;
  localparam int MINP = 64;
`ifdef MASK_BBOX_DRAW_EN
  localparam bit DRAW = 1'b1;
`else
  localparam bit DRAW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        active = 1'b0;
  logic        done, busy, we, box_valid;
  logic [7:0]  mask_in;
  logic [16:0] addr_read, addr_write, pix_count;
  logic [7:0]  data_out, y_min, y_max;
  logic [8:0]  x_min, x_max;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:N-1];
  logic [16:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  mask_bbox #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(MINP), .BOX_VALUE(8'd128)) dut (
    .clk(clk), .rst(rst), .active(active), .done(done), .busy(busy),
    .mask_in(mask_in), .addr_read(addr_read), .we(we), .addr_write(addr_write),
    .data_out(data_out), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pix_count(pix_count), .box_valid(box_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mask_in <= (int'(addr_read) < N) ? mem[addr_read] : 8'h00;
    if (we) begin
      wr_addr_q.push_back(addr_write);
      wr_data_q.push_back(data_out);
    end
  end

  typedef struct {
    int nr;
    int ax0, ay0, ax1, ay1;
    int bx0, by0, bx1, by1;
    int exmin, exmax, eymin, eymax, ecnt, ebv;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
  endtask

  task automatic paint(input int x0, input int y0, input int x1, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        mem[y * W + x] = 8'($urandom_range(1, 255));
  endtask

  // Reference: scan the frame array directly.
  task automatic model(output int xmn, output int xmx, output int ymn, output int ymx,
                       output int cnt, output int bv);
    xmn = W; xmx = -1; ymn = H; ymx = -1; cnt = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (mem[y * W + x] != 0) begin
          cnt++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
    if (cnt == 0) begin
      xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    end
    bv = (cnt >= MINP) ? 1 : 0;
  endtask

  task automatic do_pass(input string tag, input int exmin, input int exmax, input int eymin,
                         input int eymax, input int ecnt, input int ebv, input bit hold);
    int cyc;
    int explat;
    int bad;
    bit perim [0:N-1];
    int nperim;
    wr_addr_q.delete();
    wr_data_q.delete();
    explat = N + 3 + ((DRAW && ebv != 0) ? N : 0);
    @(negedge clk) active = 1'b1;
    @(posedge clk);
    if (!hold) #1 active = 1'b0;
    cyc = 0;
    while (cyc < 2 * N + 50) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 5) chk({tag, ".busy_scan"}, int'(busy), 1);
      if (done) break;
    end
    chk({tag, ".latency"}, cyc, explat);
    chk({tag, ".busy_done"}, int'(busy), 0);
    chk({tag, ".x_min"}, int'(x_min), exmin);
    chk({tag, ".x_max"}, int'(x_max), exmax);
    chk({tag, ".y_min"}, int'(y_min), eymin);
    chk({tag, ".y_max"}, int'(y_max), eymax);
    chk({tag, ".pix_count"}, int'(pix_count), ecnt);
    chk({tag, ".box_valid"}, int'(box_valid), ebv);
    if (hold) begin
      repeat (3) begin
        @(posedge clk);
        #1 chk({tag, ".done_held"}, int'(done), 1);
      end
      @(negedge clk) active = 1'b0;
    end
    @(posedge clk);
    #1 chk({tag, ".done_clear"}, int'(done), 0);
    chk({tag, ".pix_count_idle"}, int'(pix_count), ecnt);

    for (int i = 0; i < N; i++) perim[i] = 1'b0;
    if (DRAW && ebv != 0) begin
      for (int x = exmin; x <= exmax; x++) begin
        perim[eymin * W + x] = 1'b1;
        perim[eymax * W + x] = 1'b1;
      end
      for (int y = eymin; y <= eymax; y++) begin
        perim[y * W + exmin] = 1'b1;
        perim[y * W + exmax] = 1'b1;
      end
    end
    nperim = 0;
    for (int i = 0; i < N; i++) if (perim[i]) nperim++;
    chk({tag, ".write_count"}, wr_addr_q.size(), nperim);
    bad = 0;
    foreach (wr_addr_q[i])
      if (int'(wr_addr_q[i]) >= N || !perim[wr_addr_q[i]] || wr_data_q[i] != 8'd128) bad++;
    chk({tag, ".bad_writes"}, bad, 0);
  endtask

  initial begin
    int xmn, xmx, ymn, ymx, cnt, bv;
    tbl[0] = '{0,  0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 10,  5, 19, 14,  0,  0,  0,  0,  10, 19, 5, 14, 100, 1};
    tbl[2] = '{2,  0,  0,  0,  0, 63, 47, 63, 47,   0, 63, 0, 47, 2, 0};
    tbl[3] = '{1, 30, 20, 34, 24,  0,  0,  0,  0,  30, 34, 20, 24, 25, 0};
    tbl[4] = '{1,  0, 40,  7, 47,  0,  0,  0,  0,   0, 7, 40, 47, 64, 1};
    tbl[5] = '{1,  0,  0, 62,  0,  0,  0,  0,  0,   0, 62, 0, 0, 63, 0};
    tbl[6] = '{1,  0,  0, 63, 47,  0,  0,  0,  0,   0, 63, 0, 47, 3072, 1};

    clear_mem();
    #2 rst = 1'b0;
    #1;
    chk("reset.done", int'(done), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.we", int'(we), 0);
    chk("reset.addr_read", int'(addr_read), 0);
    chk("reset.pix_count", int'(pix_count), 0);
    chk("reset.box_valid", int'(box_valid), 0);
    @(negedge clk) rst = 1'b1;

    for (int t = 0; t < 7; t++) begin
      clear_mem();
      if (tbl[t].nr >= 1) paint(tbl[t].ax0, tbl[t].ay0, tbl[t].ax1, tbl[t].ay1);
      if (tbl[t].nr >= 2) paint(tbl[t].bx0, tbl[t].by0, tbl[t].bx1, tbl[t].by1);
      do_pass($sformatf("tbl%0d", t), tbl[t].exmin, tbl[t].exmax, tbl[t].eymin,
              tbl[t].eymax, tbl[t].ecnt, tbl[t].ebv, t[0]);
    end

    for (int r = 0; r < 4; r++) begin
      int x0, y0;
      clear_mem();
      x0 = $urandom_range(0, W - 12);
      y0 = $urandom_range(0, H - 12);
      paint(x0, y0, x0 + $urandom_range(0, 11), y0 + $urandom_range(0, 11));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 199) == 0) mem[i] = 8'($urandom_range(1, 255));
      model(xmn, xmx, ymn, ymx, cnt, bv);
      do_pass($sformatf("rand%0d", r), xmn, xmx, ymn, ymx, cnt, bv, r[0]);
    end

    clear_mem();
    paint(10, 5, 19, 14);
    @(negedge clk) active = 1'b1;
    repeat (1000) @(posedge clk);
    #1 chk("abort.busy_before", int'(busy), 1);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.addr_read", int'(addr_read), 0);
    chk("abort.pix_count", int'(pix_count), 0);
    chk("abort.x_max", int'(x_max), 0);
    chk("abort.box_valid", int'(box_valid), 0);
    active = 1'b0;
    @(negedge clk) rst = 1'b1;
    model(xmn, xmx, ymn, ymx, cnt, bv);
    do_pass("after_abort", xmn, xmx, ymn, ymx, cnt, bv, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
